// File: rtl/shf_pkg.sv
// Shared types and constants for the iterative shift sequencer.
package shf_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int AMT_W      = 4;
    localparam int IR_DIR     = 4;
    localparam int IR_ARITH   = 5;
    localparam int IR_AMT_MSB = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_LSHF  = 2'd0,
        OP_RSHFL = 2'd1,
        OP_RSHFA = 2'd2
    } op_e;

    // The arithmetic bit only matters for right shifts.
    function automatic op_e decode_op(input logic [5:0] ir);
        if (!ir[IR_DIR])        return OP_LSHF;
        else if (!ir[IR_ARITH]) return OP_RSHFL;
        else                    return OP_RSHFA;
    endfunction

endpackage

// File: rtl/shf_step.sv
// One bounded shift step: shifts WIDTH bits by 0..STEP_MAX positions as selected by op.
module shf_step
    import shf_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int STEP_MAX = 4,
    localparam int SW      = $clog2(STEP_MAX + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SW-1:0]    amt_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        unique case (op_i)
            OP_LSHF:  data_o = data_i << amt_i;
            OP_RSHFL: data_o = data_i >> amt_i;
            OP_RSHFA: data_o = $signed(data_i) >>> amt_i;
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shf_iter_ctrl.sv
// Multi-cycle LSHF/RSHFL/RSHFA sequencer, at most STEP_MAX bits per cycle.
// Optional early termination input ABORT is enabled by defining SHF_ITER_ABORT_EN.
module shf_iter_ctrl
    import shf_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int STEP_MAX = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [5:0]       IR,
`ifdef SHF_ITER_ABORT_EN
    input  logic             ABORT,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SHF_out
);

    localparam int SW                    = $clog2(STEP_MAX + 1);
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP_MAX);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic [AMT_W-1:0]   step_amt;
    logic [WIDTH-1:0]   step_res;
    logic               abort;

`ifdef SHF_ITER_ABORT_EN
    assign abort = ABORT;
`else
    assign abort = 1'b0;
`endif

    assign step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;

    shf_step #(
        .WIDTH    (WIDTH),
        .STEP_MAX (STEP_MAX)
    ) u_step (
        .data_i (acc_q),
        .amt_i  (step_amt[SW-1:0]),
        .op_i   (op_q),
        .data_o (step_res)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            op_q    <= OP_LSHF;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    // acc is left untouched outside SHIFT so the result stays stable until the next accept.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    acc_d   = A;
                    rem_d   = IR[IR_AMT_MSB:0];
                    op_d    = decode_op(IR);
                    state_d = (IR[IR_AMT_MSB:0] == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_res;
                    rem_d = rem_q - step_amt;
                    if (rem_d == '0) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = (state_q == S_DONE) && !abort;
    assign SHF_out = acc_q;

endmodule

// File: tb/tb_shf_iter_ctrl.sv
// Self-checking bench for shf_iter_ctrl against a single-step barrel-shift reference model.
// Covers the ABORT port only when SHF_ITER_ABORT_EN is defined.
module tb_shf_iter_ctrl;

    localparam int WIDTH    = 16;
    localparam int STEP_MAX = 4;

    logic             CLK;
    logic             RESET;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [5:0]       IR;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SHF_out;
`ifdef SHF_ITER_ABORT_EN
    logic             ABORT;
`endif

    int checks = 0;
    int errors = 0;

    shf_iter_ctrl #(
        .WIDTH    (WIDTH),
        .STEP_MAX (STEP_MAX)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .A       (A),
        .IR      (IR),
`ifdef SHF_ITER_ABORT_EN
        .ABORT   (ABORT),
`endif
        .BUSY    (BUSY),
        .DONE    (DONE),
        .SHF_out (SHF_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Whole shift done in one go; the DUT must arrive at the same value in steps.
    function automatic logic [WIDTH-1:0] refShift(input logic [WIDTH-1:0] a, input logic [5:0] ir);
        logic signed [WIDTH-1:0] sa;
        int amt;
        amt = int'(ir[3:0]);
        sa  = a;
        if (!ir[4])      return a << amt;
        else if (!ir[5]) return a >> amt;
        else             return sa >>> amt;
    endfunction

    function automatic int refLatency(input logic [3:0] amt);
        return (int'(amt) + STEP_MAX - 1) / STEP_MAX + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single edge, then scrambles A/IR to prove they were captured.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [5:0] ir);
        @(negedge CLK);
        A     = a;
        IR    = ir;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A     = WIDTH'($urandom);
        IR    = 6'($urandom);
    endtask

    task automatic runOp(input logic [WIDTH-1:0] a, input logic [5:0] ir, input bit noisy);
        logic [WIDTH-1:0] expected;
        int lat;
        expected = refShift(a, ir);
        lat      = refLatency(ir[3:0]);
        applyStimulus(a, ir);
        for (int k = 1; k <= lat; k++) begin
            checkOutput("busy_in_op", 32'(BUSY), 32'd1);
            checkOutput("done_timing", 32'(DONE), 32'(k == lat));
            if (k == lat) checkOutput("result", 32'(SHF_out), 32'(expected));
            if (noisy) START = 1'($urandom_range(0, 1));
            @(posedge CLK);
            #1;
        end
        START = 1'b0;
        checkOutput("idle_busy", 32'(BUSY), 32'd0);
        checkOutput("idle_done", 32'(DONE), 32'd0);
        checkOutput("result_hold", 32'(SHF_out), 32'(expected));
    endtask

    initial begin
        RESET = 1'b1;
        START = 1'b0;
        A     = '0;
        IR    = '0;
`ifdef SHF_ITER_ABORT_EN
        ABORT = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_busy", 32'(BUSY), 32'd0);
        checkOutput("reset_done", 32'(DONE), 32'd0);
        checkOutput("reset_out", 32'(SHF_out), 32'd0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("post_reset_busy", 32'(BUSY), 32'd0);

        // Directed cases from the plan: RSHFA, both max-distance shifts, zero amount.
        runOp(16'h8001, 6'b110011, 1'b0);
        runOp(16'h0001, 6'b001111, 1'b0);
        runOp(16'h8000, 6'b011111, 1'b0);
        runOp(16'h1234, 6'b100000, 1'b0);
        runOp(16'hA5C3, 6'b111111, 1'b0);
        runOp(16'h7F0F, 6'b110100, 1'b0);

        // START held high: accepts every third cycle, never while busy or in DONE.
        @(negedge CLK);
        A     = 16'h00F0;
        IR    = 6'b010100;
        START = 1'b1;
        @(posedge CLK);
        #1;
        for (int k = 1; k <= 12; k++) begin
            checkOutput("held_busy", 32'(BUSY), 32'((k % 3) != 0));
            checkOutput("held_done", 32'(DONE), 32'((k % 3) == 2));
            if ((k % 3) != 1) checkOutput("held_out", 32'(SHF_out), 32'h000F);
            if (k == 11) START = 1'b0;
            @(posedge CLK);
            #1;
        end
        checkOutput("held_idle", 32'(BUSY), 32'd0);

        // Reset in the second SHIFT cycle of a 12-bit shift discards the op.
        applyStimulus(16'h0F0F, 6'b001100);
        checkOutput("rst_mid_busy1", 32'(BUSY), 32'd1);
        @(posedge CLK);
        #1;
        checkOutput("rst_mid_busy2", 32'(BUSY), 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        checkOutput("rst_mid_idle", 32'(BUSY), 32'd0);
        checkOutput("rst_mid_out", 32'(SHF_out), 32'd0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("rst_mid_nodone", 32'(DONE), 32'd0);
            @(posedge CLK);
            #1;
        end
        runOp(16'h0F0F, 6'b001100, 1'b0);

`ifdef SHF_ITER_ABORT_EN
        applyStimulus(16'h1357, 6'b001100);
        ABORT = 1'b1;
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        checkOutput("abort_busy", 32'(BUSY), 32'd0);
        checkOutput("abort_done", 32'(DONE), 32'd0);
        @(negedge CLK);
        ABORT = 1'b1;
        applyStimulus(16'h2468, 6'b000000);
        ABORT = 1'b0;
        checkOutput("abort_start_done", 32'(DONE), 32'd1);
        checkOutput("abort_start_out", 32'(SHF_out), 32'h2468);
        @(posedge CLK);
        #1;
`endif

        // Random ops with START noise while busy.
        for (int n = 0; n < 40; n++) begin
            runOp(WIDTH'($urandom), 6'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
